instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address; valid while imem_req=1.
REQ-006 imem_ready  input  1  memory accepts request this cycle when imem_req & imem_ready.
REQ-007 imem_rvalid  input  1  response valid; at least 1 cycle after acceptance.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  branch/jump redirect strobe, one cycle.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 inst_valid  output  1  instruction available to decode stage.
REQ-012 inst_ready  input  1  decode stage consumes when inst_valid & inst_ready.
REQ-013 instruction  output  32  raw instruction word feeding the field decoder.
REQ-014 inst_pc  output  32  address of presented instruction.
REQ-015 fetch_err  output  1  misaligned-target flag (see Configuration).

Function
REQ-016 States: FETCH, WAIT, OUT, DRAIN; at most one outstanding memory request.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on acceptance -> WAIT.
REQ-018 WAIT: imem_req=0; on imem_rvalid register imem_rdata to instruction, pc to inst_pc, -> OUT.
REQ-019 OUT: inst_valid=1, instruction/inst_pc held stable until handshake; on handshake pc<=pc+4 (mod 2^32 wrap), -> FETCH.
REQ-020 Latency: instruction visible the cycle after imem_rvalid; minimum 3 cycles per instruction with zero-wait memory.
REQ-021 redirect has priority over all other events; pc<=redirect_pc in the same edge.
REQ-022 redirect in FETCH without acceptance, or in OUT (including same cycle as inst_ready): inst_valid drops next cycle, no pc+4, -> FETCH.
REQ-023 redirect in FETCH with acceptance same cycle, or in WAIT without imem_rvalid: -> DRAIN.
REQ-024 redirect in WAIT with imem_rvalid same cycle: response discarded, -> FETCH.
REQ-025 DRAIN: imem_req=0, inst_valid=0; next imem_rvalid discarded, -> FETCH; further redirect updates pc, stays DRAIN.
REQ-026 imem_rvalid outside WAIT/DRAIN is ignored.
REQ-027 inst_valid SHALL never assert for a discarded response.

Reset
REQ-028 While reset=1: state FETCH-pending, imem_req=0, inst_valid=0, instruction=0, inst_pc=0, fetch_err=0, pc=RESET_PC.
REQ-029 First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
REQ-030 Reset mid-request abandons the outstanding response; a late imem_rvalid after reset is ignored.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_err=1 (sticky until reset), state -> DRAIN/FETCH held idle with imem_req=0.
REQ-032 Macro undefined: redirect_pc[1:0] forced to 2'b00, fetch_err tied 0.

Structure
REQ-033 Package fetch_pkg: state enumeration, ILEN=32, PC_INC=4, default RESET_PC constant.
REQ-034 One sub-module fetch_pc: pc register and next-pc mux (hold/+4/redirect); FSM and output register in instruction_fetch.

Verification
REQ-035 Reset release, zero-wait memory returning 32'h0000_0013 -> imem_addr 0,4,8; inst_valid every 3rd cycle with inst_pc 0,4,8.
REQ-036 inst_ready held 0 for 5 cycles in OUT -> instruction/inst_pc stable, no new imem_req.
REQ-037 redirect to 32'h0000_0100 during WAIT, rvalid 2 cycles later -> response dropped, next imem_addr 32'h0000_0100, no inst_valid for dropped word.
REQ-038 redirect to 32'h0000_0200 same cycle as inst_ready in OUT -> next imem_addr 32'h0000_0200, not pc+4.
REQ-039 pc=32'hFFFF_FFFC handshake -> next imem_addr 32'h0000_0000.
REQ-040 With FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h0000_0102 -> fetch_err=1, imem_req=0 until reset; without macro -> imem_addr 32'h0000_0100.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] PC_INC           = 32'd4;
  localparam logic [ILEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] ALIGN_MASK       = 32'h0000_0003;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_OUT   = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PCSEL_HOLD = 2'd0,
    PCSEL_STEP = 2'd1,
    PCSEL_LOAD = 2'd2
  } pc_sel_e;

  function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] pc);
    return pc & ~ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Memory, redirect and decode-side signals of the fetch unit.
// Revision : 1.0
// ============================================================================
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [ILEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect;
  logic [ILEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] instruction;
  logic [ILEN-1:0] inst_pc;
  logic            fetch_err;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, inst_pc, fetch_err,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, inst_pc, fetch_err,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc
// Brief    : Program counter register with hold / +4 / redirect-load select.
// Revision : 1.0
// ============================================================================
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire pc_sel_e         i_pc_sel,
  input  wire logic [ILEN-1:0] i_load_pc,
  output logic [ILEN-1:0]      o_pc
);

  logic [ILEN-1:0] r_pc;
  logic [ILEN-1:0] w_pc_next;

  // The +4 step wraps naturally at 2^32.
  always_comb begin
    w_pc_next = r_pc;
    case (i_pc_sel)
      PCSEL_STEP: w_pc_next = r_pc + PC_INC;
      PCSEL_LOAD: w_pc_next = i_load_pc;
      default:    w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Single-outstanding fetch FSM; redirects drain in-flight responses.
//            FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_err.
// Revision : 1.0
// ============================================================================
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  wire logic            clk,
  input  wire logic            reset,
  instruction_fetch_if.master  bus
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  pc_sel_e         w_pc_sel;
  logic [ILEN-1:0] w_pc;
  logic [ILEN-1:0] w_target;
  logic [ILEN-1:0] r_instruction;
  logic [ILEN-1:0] r_inst_pc;
  logic            w_trapped;
  logic            w_req;
  logic            w_accept;
  logic            w_valid;
  logic            w_handshake;
  logic            w_capture;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fetch_err;

  assign w_target  = bus.redirect_pc;
  assign w_trapped = r_fetch_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_err <= 1'b0;
    end else if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
      r_fetch_err <= 1'b1;
    end
  end

  assign bus.fetch_err = r_fetch_err & ~reset;
`else
  assign w_target      = align_pc(bus.redirect_pc);
  assign w_trapped     = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk       (clk),
    .rst       (reset),
    .i_pc_sel  (w_pc_sel),
    .i_load_pc (w_target),
    .o_pc      (w_pc)
  );

  // Outputs are masked during reset so the first reset cycle is already quiet.
  assign w_req       = (r_state == ST_FETCH) && !reset && !w_trapped;
  assign w_valid     = (r_state == ST_OUT) && !reset;
  assign w_accept    = w_req && bus.imem_ready;
  assign w_handshake = w_valid && bus.inst_ready;

  always_comb begin
    w_state_next = r_state;
    w_pc_sel     = PCSEL_HOLD;
    w_capture    = 1'b0;
    if (bus.redirect) begin
      // A response still in flight after the redirect must be swallowed in DRAIN.
      w_pc_sel = PCSEL_LOAD;
      case (r_state)
        ST_FETCH: w_state_next = w_accept ? ST_DRAIN : ST_FETCH;
        ST_WAIT:  w_state_next = bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
        ST_OUT:   w_state_next = ST_FETCH;
        ST_DRAIN: w_state_next = bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
        default:  w_state_next = ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_accept) begin
            w_state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            w_capture    = 1'b1;
            w_state_next = ST_OUT;
          end
        end
        ST_OUT: begin
          if (w_handshake) begin
            w_pc_sel     = PCSEL_STEP;
            w_state_next = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_rvalid) begin
            w_state_next = ST_FETCH;
          end
        end
        default: w_state_next = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instruction <= '0;
      r_inst_pc     <= '0;
    end else if (w_capture) begin
      r_instruction <= bus.imem_rdata;
      r_inst_pc     <= w_pc;
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = w_pc;
  assign bus.inst_valid  = w_valid;
  assign bus.instruction = r_instruction;
  assign bus.inst_pc     = r_inst_pc;

endmodule
`default_nettype wire
